// File: rtl/diff_tx_pkg.sv
// Shared types and helpers for the differential tristate serializer.
// State encodings are fixed so older netlists and probes keep their meaning.
package diff_tx_pkg;

  localparam logic [2:0] ST_HIZ    = 3'd0;
  localparam logic [2:0] ST_PRE    = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_PARITY = 3'd4;
  localparam logic [2:0] ST_STOP   = 3'd5;
  localparam logic [2:0] ST_LINGER = 3'd6;

  typedef enum logic [2:0] {
    HIZ    = ST_HIZ,
    PRE    = ST_PRE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP,
    LINGER = ST_LINGER
  } tx_state_e;

  localparam logic TX_IDLE_LEVEL = 1'b1;
  localparam logic TX_T_HIZ      = 1'b1;

  // Width needed to count 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/diff_tx_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
// A clear restarts the period so every state begins on a fresh bit boundary.
module diff_tx_baud_tick
  import diff_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/diff_tx_serializer.sv
// Serialises handshaked words into start/data/stop frames for an OBUFTDS-style pair,
// releasing the pair to high-Z after an idle linger; DIFF_TX_PARITY_EN adds an even-parity bit.
module diff_tx_serializer
  import diff_tx_pkg::*;
#(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned CLKS_PER_BIT  = 4,
  parameter int unsigned HIZ_IDLE_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_o,
  output logic              tx_t,
  output logic              busy
);

  localparam int unsigned BIT_MAX = (DATA_W > HIZ_IDLE_BITS) ? DATA_W : HIZ_IDLE_BITS;
  localparam int unsigned BW = cnt_width(BIT_MAX);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_IDLE = BW'(HIZ_IDLE_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              tx_o_q, tx_o_d;
  logic              tx_t_q, tx_t_d;
  logic              busy_q, busy_d;
`ifdef DIFF_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic accept;
  logic tick;
  logic baud_clear;

  assign in_ready   = (state_q == HIZ) || (state_q == LINGER);
  assign accept     = in_valid && in_ready;
  assign baud_clear = (state_d != state_q);

  diff_tx_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
`ifdef DIFF_TX_PARITY_EN
    parity_d = parity_q;
    if (accept) begin
      parity_d = ^in_data;
    end
`endif
    unique case (state_q)
      HIZ: begin
        if (accept) begin
          state_d = PRE;
          shift_d = in_data;
        end
      end
      PRE: begin
        if (tick) state_d = START;
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
`ifdef DIFF_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef DIFF_TX_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) state_d = LINGER;
      end
      LINGER: begin
        // A new word wins over idle expiry, so back-to-back frames skip the preamble.
        if (accept) begin
          state_d = START;
          shift_d = in_data;
        end else if (tick) begin
          if (bit_q == LAST_IDLE) begin
            state_d = HIZ;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = HIZ;
      end
    endcase
    if (state_d != state_q) begin
      bit_d = '0;
    end
  end

  // Outputs are decoded from the next state so the registered pins line up with state_q.
  always_comb begin
    tx_o_d = TX_IDLE_LEVEL;
    unique case (state_d)
      START:   tx_o_d = ~TX_IDLE_LEVEL;
      DATA:    tx_o_d = shift_d[0];
`ifdef DIFF_TX_PARITY_EN
      PARITY:  tx_o_d = parity_d;
`endif
      default: tx_o_d = TX_IDLE_LEVEL;
    endcase
    tx_t_d = (state_d == HIZ) ? TX_T_HIZ : ~TX_T_HIZ;
    busy_d = (state_d != HIZ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HIZ;
      shift_q <= '0;
      bit_q   <= '0;
      tx_o_q  <= TX_IDLE_LEVEL;
      tx_t_q  <= TX_T_HIZ;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_o_q  <= tx_o_d;
      tx_t_q  <= tx_t_d;
      busy_q  <= busy_d;
    end
  end

`ifdef DIFF_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  assign tx_o = tx_o_q;
  assign tx_t = tx_t_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_diff_tx_serializer.sv
// Randomised bench: a frame-level waveform model predicts every cycle of tx_o/tx_t/busy/in_ready.
module tb_diff_tx_serializer;

  localparam int DW   = 8;
  localparam int CPB  = 4;
  localparam int IDLE = 2;

  typedef struct packed {
    logic rdy;
    logic busy;
    logic t;
    logic o;
  } samp_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          tx_o;
  logic          tx_t;
  logic          busy;

  int    checks;
  int    errors;
  int    cyc;
  bit    accepted;
  samp_t exp_q[$];

  diff_tx_serializer #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB),
    .HIZ_IDLE_BITS(IDLE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx_o    (tx_o),
    .tx_t    (tx_t),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h exp %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic samp_t mk(input logic rdy, input logic bsy, input logic t, input logic o);
    samp_t s;
    s.rdy  = rdy;
    s.busy = bsy;
    s.t    = t;
    s.o    = o;
    return s;
  endfunction

  task automatic push_n(input samp_t s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(s);
  endtask

  // Expected line activity for one frame, starting the cycle after acceptance.
  task automatic push_frame(input logic [DW-1:0] w, input bit with_pre);
    if (with_pre) push_n(mk(1'b0, 1'b1, 1'b0, 1'b1), CPB);
    push_n(mk(1'b0, 1'b1, 1'b0, 1'b0), CPB);
    for (int i = 0; i < DW; i++) push_n(mk(1'b0, 1'b1, 1'b0, w[i]), CPB);
`ifdef DIFF_TX_PARITY_EN
    push_n(mk(1'b0, 1'b1, 1'b0, ^w), CPB);
`endif
    push_n(mk(1'b0, 1'b1, 1'b0, 1'b1), CPB);
    push_n(mk(1'b1, 1'b1, 1'b0, 1'b1), IDLE * CPB);
  endtask

  // Check the current cycle, advance the model across the next rising edge.
  task automatic step();
    samp_t h;
    bit    was_hiz;
    @(negedge clk);
    was_hiz = (exp_q.size() == 0);
    h = was_hiz ? mk(1'b1, 1'b0, 1'b1, 1'b1) : exp_q[0];
    chk("in_ready", in_ready, h.rdy);
    chk("busy", busy, h.busy);
    chk("tx_t", tx_t, h.t);
    chk("tx_o", tx_o, h.o);
    if (!was_hiz) void'(exp_q.pop_front());
    if (rst) begin
      exp_q.delete();
    end else if (in_valid && h.rdy) begin
      exp_q.delete();
      push_frame(in_data, was_hiz);
      accepted = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [DW-1:0] w);
    int budget;
    budget   = 0;
    accepted = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    while (!accepted && budget < 200) begin
      step();
      budget++;
    end
    chk("accept_timeout", accepted, 1'b1);
    in_valid = 1'b0;
    in_data  = DW'($urandom);
  endtask

  task automatic drain();
    int budget;
    budget   = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && budget < 300) begin
      step();
      budget++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    idle(2);
  endtask

  // Present the next word exactly on the final LINGER cycle.
  task automatic send_at_expiry(input logic [DW-1:0] w);
    int budget;
    budget   = 0;
    in_valid = 1'b0;
    while (exp_q.size() > 1 && budget < 300) begin
      step();
      budget++;
    end
    send(w);
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
  endtask

  initial begin
    int r;
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    accepted = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    idle(20);
    send(8'hA5);
    drain();

    send(8'h00);
    send(8'hFF);
    drain();

    send(8'h55);
    idle(12);
    send(8'h3C);
    drain();

    send(8'h81);
    idle(4 + 4 + 3 * CPB + 1);
    pulse_reset();
    idle(3);
    send(8'h81);
    drain();

    send(8'h07);
    send(8'h03);
    drain();

    send(8'h5A);
    send_at_expiry(8'hC3);
    drain();

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        send(DW'($urandom));
      end else if (r < 6) begin
        idle($urandom_range(0, 60));
        send(DW'($urandom));
      end else if (r < 8) begin
        send_at_expiry(DW'($urandom));
      end else if (r < 9) begin
        drain();
        send(DW'($urandom));
      end else begin
        idle($urandom_range(1, 40));
        pulse_reset();
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
